// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse-train generator and its counters.
// Optional abort input is enabled by defining PULSE_GEN_ABORT_EN.
package pulse_gen_pkg;

  localparam int PULSE_GEN_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_len_counter.sv
// W-bit loadable down-counter with zero flag; load wins over enable.
// Decrement saturates at zero so the count can never wrap.
module pulse_len_counter
  import pulse_gen_pkg::*;
#(
  parameter int W = PULSE_GEN_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= '0;
    end else if (load) begin
      val <= load_val;
    end else if (en && (val != '0)) begin
      val <= val - 1'b1;
    end
  end

  assign zero = (val == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Serial pulse-train generator: count pulses of high_len high / low_len low, then a done strobe.
// Optional abort input when PULSE_GEN_ABORT_EN is defined.
module pulse_train_generator
  import pulse_gen_pkg::*;
#(
  parameter int W = PULSE_GEN_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] high_len,
  input  logic [W-1:0] low_len,
  input  logic [W-1:0] count,
`ifdef PULSE_GEN_ABORT_EN
  input  logic         abort,
`endif
  output logic         ready,
  output logic         out,
  output logic         done
);

  state_t       state, state_nxt;
  logic [W-1:0] hi_m1, lo_m1;
  logic         accept, kill;
  logic         ph_load, ph_en, ph_zero;
  logic [W-1:0] ph_val;
  logic         rem_load, rem_en, rem_zero;

  function automatic logic [W-1:0] eff_m1(input logic [W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  assign accept = start && (state == ST_IDLE);

`ifdef PULSE_GEN_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remaining is decremented as each pulse enters its gap, so at the end of
  // a gap rem_zero already means "that was the last pulse".
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && (count != '0)) state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (kill)         state_nxt = ST_IDLE;
        else if (ph_zero) state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (kill)         state_nxt = ST_IDLE;
        else if (ph_zero) state_nxt = rem_zero ? ST_IDLE : ST_HIGH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == ST_IDLE);
    ph_load  = 1'b0;
    ph_en    = 1'b0;
    ph_val   = '0;
    rem_load = 1'b0;
    rem_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && (count != '0)) begin
          ph_load  = 1'b1;
          ph_val   = eff_m1(high_len);
          rem_load = 1'b1;
        end
      end
      ST_HIGH: begin
        if (ph_zero) begin
          ph_load = 1'b1;
          ph_val  = lo_m1;
          rem_en  = 1'b1;
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (ph_zero) begin
          ph_load = 1'b1;
          ph_val  = hi_m1;
        end else begin
          ph_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_m1 <= '0;
      lo_m1 <= '0;
      out   <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (accept) begin
        hi_m1 <= eff_m1(high_len);
        lo_m1 <= eff_m1(low_len);
      end
      out  <= (state_nxt == ST_HIGH);
      done <= ((state == ST_LOW) && ph_zero && rem_zero && !kill) ||
              (accept && (count == '0));
    end
  end

  pulse_len_counter #(.W(W)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ph_en),
    .zero     (ph_zero)
  );

  pulse_len_counter #(.W(W)) u_remain (
    .clk      (clk),
    .rst      (rst),
    .load     (rem_load),
    .load_val (count),
    .en       (rem_en),
    .zero     (rem_zero)
  );

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: per-cycle vector table plus reset/abort sequences.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] high_len = '0;
  logic [3:0] low_len = '0;
  logic [3:0] count = '0;
`ifdef PULSE_GEN_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       ready, out, done;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_train_generator #(.W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .high_len (high_len),
    .low_len  (low_len),
    .count    (count),
`ifdef PULSE_GEN_ABORT_EN
    .abort    (abort),
`endif
    .ready    (ready),
    .out      (out),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [3:0] hl;
    logic [3:0] ll;
    logic [3:0] cnt;
    logic       e_out;
    logic       e_rdy;
    logic       e_done;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic e_out, input logic e_rdy, input logic e_done);
    chk({tag, " out"},   out,   e_out);
    chk({tag, " ready"}, ready, e_rdy);
    chk({tag, " done"},  done,  e_done);
  endtask

  initial begin
    // Row: inputs applied this cycle, outputs expected in this same cycle.
    vecs[0]  = '{1'b1, 4'd1,  4'd1,  4'd3, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd15, 4'd15, 4'd5, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd2,  4'd1,  4'd1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd3,  4'd2,  4'd1, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 4'd0,  4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd0,  4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 4'd0,  4'd0,  4'd1, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 4'd5,  4'd5,  4'd0, 1'b0, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b0, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 4'd9,  4'd9,  4'd9, 1'b0, 1'b1, 1'b0};

    // Reset held, then released.
    repeat (2) @(negedge clk);
    chk3("in_reset", 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk3("after_reset", 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 23; i++) begin
      if (i != 0) @(negedge clk);
      chk3($sformatf("row%0d", i), vecs[i].e_out, vecs[i].e_rdy, vecs[i].e_done);
      start    = vecs[i].st;
      high_len = vecs[i].hl;
      low_len  = vecs[i].ll;
      count    = vecs[i].cnt;
    end

    // Asynchronous reset in the middle of a high phase.
    @(negedge clk);
    start = 1'b1; high_len = 4'd4; low_len = 4'd1; count = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk3("rst_seq high1", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk3("rst_seq high2", 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk3("rst_seq async", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk3($sformatf("rst_seq idle%0d", i), 1'b0, 1'b1, 1'b0);
    end
    start = 1'b1; high_len = 4'd1; low_len = 4'd1; count = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk3("fresh high", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk3("fresh low", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk3("fresh done", 1'b0, 1'b1, 1'b1);

`ifdef PULSE_GEN_ABORT_EN
    // Abort in idle alongside start: start still accepted.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; high_len = 4'd4; low_len = 4'd1; count = 4'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk3("abort high1", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk3("abort high2", 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk3("abort idle", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk3("abort no_done", 1'b0, 1'b1, 1'b0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
